queue_op_arbiter: RTL and testbench

QUEUE_OP_ARBITER -- requirements
Module: queue_op_arbiter

---
 rtl/queue_op_arbiter_if.sv | 48 ++++
 rtl/queue_op_arbiter.sv | 179 +++++++++++++++++
 tb/tb_queue_op_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_op_arbiter_if.sv
// Bundle of requester command lanes, queue command/status lines and the
// response strobe. The arbiter takes the master view; requesters and the
// queue model take the slave view.
interface queue_op_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 64,
    parameter int PTR_WIDTH = 6
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [2*NUM_REQ-1:0]         req_flag;
    logic [PTR_WIDTH*NUM_REQ-1:0] req_index;
    logic [DATA_SIZE*NUM_REQ-1:0] req_data;

    logic                         q_op_valid;
    logic [1:0]                   q_op_flag;
    logic [PTR_WIDTH-1:0]         q_op_index;
    logic [DATA_SIZE-1:0]         q_op_data;
    logic                         q_full;
    logic                         q_empty;
    logic                         q_error_reg;
    logic                         q_error_rem;
    logic                         q_error_time;
    logic [DATA_SIZE-1:0]         q_pop_data;

    logic                         rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [1:0]                   rsp_status;
    logic [DATA_SIZE-1:0]         rsp_data;

    modport master (
        input  req_valid, req_flag, req_index, req_data,
        input  q_full, q_empty, q_error_reg, q_error_rem, q_error_time, q_pop_data,
        output req_ready,
        output q_op_valid, q_op_flag, q_op_index, q_op_data,
        output rsp_valid, rsp_id, rsp_status, rsp_data
    );

    modport slave (
        output req_valid, req_flag, req_index, req_data,
        output q_full, q_empty, q_error_reg, q_error_rem, q_error_time, q_pop_data,
        input  req_ready,
        input  q_op_valid, q_op_flag, q_op_index, q_op_data,
        input  rsp_valid, rsp_id, rsp_status, rsp_data
    );
endinterface

// File: rtl/queue_op_arbiter.sv
// Round-robin arbiter that serialises push/pop/remove/modify commands from
// several requesters onto a single queue port, one command in flight.
//
// state | meaning
// IDLE  | wait for any req_valid, grant one requester and latch its command
// ISSUE | drive the command to the queue, or reject a push-when-full / pop-when-empty
// CHECK | read the registered queue error flags, retry a timed-out pop
// RESP  | one-cycle response strobe to the granted requester
module queue_op_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 64,
    parameter int PTR_WIDTH = 6,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic reset,
    queue_op_arbiter_if.master bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] OP_PUSH   = 2'b00;
    localparam logic [1:0] OP_POP    = 2'b01;
    localparam logic [1:0] OP_REMOVE = 2'b10;
    localparam logic [1:0] OP_MODIFY = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_REJECT  = 2'b01;
    localparam logic [1:0] ST_INDEX   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;

    state_t               state, state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [RT_W-1:0]      retry;
    logic [ID_W-1:0]      cmd_id;
    logic [1:0]           cmd_flag;
    logic [PTR_WIDTH-1:0] cmd_index;
    logic [DATA_SIZE-1:0] cmd_data;
    logic [DATA_SIZE-1:0] pop_data;
    logic [1:0]           status;

    logic                 any_valid;
    logic [ID_W-1:0]      gnt_id;
    logic [1:0]           sel_flag;
    logic [PTR_WIDTH-1:0] sel_index;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 grant;
    logic                 issue;
    logic                 retry_inc;
    logic                 status_load;
    logic [1:0]           status_val;
    logic [NUM_REQ-1:0]   ready_vec;

    // q_error_reg is sticky inside the queue and deliberately plays no part in status.
    logic unused_error_reg;
    assign unused_error_reg = bus.q_error_reg;

    // Round-robin pick: first valid requester at or after rr_ptr, plus its command lanes.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        sel_flag  = '0;
        sel_index = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && bus.req_valid[ID_W'(idx)]) begin
                any_valid = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(gnt_id) == i) begin
                sel_flag  = bus.req_flag[2*i +: 2];
                sel_index = bus.req_index[PTR_WIDTH*i +: PTR_WIDTH];
                sel_data  = bus.req_data[DATA_SIZE*i +: DATA_SIZE];
            end
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        issue       = 1'b0;
        retry_inc   = 1'b0;
        status_load = 1'b0;
        status_val  = ST_OK;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if ((cmd_flag == OP_PUSH && bus.q_full) ||
                    (cmd_flag == OP_POP  && bus.q_empty)) begin
                    status_load = 1'b1;
                    status_val  = ST_REJECT;
                    state_next  = RESP;
                end else begin
                    issue      = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                status_load = 1'b1;
                state_next  = RESP;
                if (cmd_flag == OP_POP && bus.q_error_time) begin
                    if (int'(retry) < MAX_RETRY) begin
                        status_load = 1'b0;
                        retry_inc   = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        status_val = ST_TIMEOUT;
                    end
                end else if ((cmd_flag == OP_REMOVE || cmd_flag == OP_MODIFY) &&
                             bus.q_error_rem) begin
                    status_val = ST_INDEX;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One-hot grant pulse toward the requesters.
    always_comb begin
        ready_vec         = '0;
        ready_vec[gnt_id] = grant;
    end

    assign bus.req_ready  = ready_vec;
    assign bus.q_op_valid = issue;
    assign bus.q_op_flag  = issue ? cmd_flag  : '0;
    assign bus.q_op_index = issue ? cmd_index : '0;
    assign bus.q_op_data  = issue ? cmd_data  : '0;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = (state == RESP) ? cmd_id : '0;
    assign bus.rsp_status = (state == RESP) ? status : '0;
    assign bus.rsp_data   = (state == RESP && status == ST_OK && cmd_flag == OP_POP) ?
                            pop_data : '0;

    // State register, round-robin pointer, latched command and response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            retry     <= '0;
            cmd_id    <= '0;
            cmd_flag  <= '0;
            cmd_index <= '0;
            cmd_data  <= '0;
            pop_data  <= '0;
            status    <= ST_OK;
        end else begin
            state <= state_next;
            if (grant) begin
                rr_ptr    <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
                cmd_id    <= gnt_id;
                cmd_flag  <= sel_flag;
                cmd_index <= sel_index;
                cmd_data  <= sel_data;
                retry     <= '0;
                pop_data  <= '0;
                status    <= ST_OK;
            end
            if (issue && cmd_flag == OP_POP) pop_data <= bus.q_pop_data;
            if (retry_inc) retry <= retry + 1'b1;
            if (status_load) status <= status_val;
        end
    end
endmodule

// File: tb/tb_queue_op_arbiter.sv
// Directed bench for queue_op_arbiter: single-command latency/status cases,
// round-robin fairness with all requesters held valid, pop retry paths and
// reset in the middle of a command.
module tb_queue_op_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    queue_op_arbiter_if #(.NUM_REQ(4), .DATA_SIZE(64), .PTR_WIDTH(6)) bus ();

    queue_op_arbiter #(.NUM_REQ(4), .DATA_SIZE(64), .PTR_WIDTH(6), .MAX_RETRY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the last run_cmd call.
    logic [3:0]  r_ready;
    int          r_pulses;
    int          r_first_c;
    int          r_last_c;
    logic [1:0]  r_op_flag;
    logic [5:0]  r_op_index;
    logic [63:0] r_op_data;
    int          r_zero_viol;
    int          r_rsp_c;
    int          r_rsp_cnt;
    logic [1:0]  r_rsp_id;
    logic [1:0]  r_status;
    logic [63:0] r_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = '0;
        bus.q_full       = 1'b0;
        bus.q_empty      = 1'b0;
        bus.q_error_reg  = 1'b0;
        bus.q_error_rem  = 1'b0;
        bus.q_error_time = 1'b0;
        bus.q_pop_data   = '0;
    endtask

    // One requester issues one command at c==0; queue status is held for 16
    // cycles, q_error_time is high for every cycle c <= time_until and
    // q_pop_data is 0x1000+c.
    task automatic run_cmd(input int id, input logic [1:0] flag, input logic [5:0] idx,
                           input logic [63:0] data, input logic full, input logic empty,
                           input int time_until, input logic rem_err, input logic reg_err);
        r_ready = '0; r_pulses = 0; r_first_c = -1; r_last_c = -1;
        r_op_flag = '0; r_op_index = '0; r_op_data = '0; r_zero_viol = 0;
        r_rsp_c = -1; r_rsp_cnt = 0; r_rsp_id = '0; r_status = '0; r_data = '0;
        bus.req_flag[2*id +: 2]   = flag;
        bus.req_index[6*id +: 6]  = idx;
        bus.req_data[64*id +: 64] = data;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.req_valid    = (c == 0) ? (4'b0001 << id) : 4'b0000;
            bus.q_full       = full;
            bus.q_empty      = empty;
            bus.q_error_time = (c <= time_until);
            bus.q_error_rem  = rem_err;
            bus.q_error_reg  = reg_err;
            bus.q_pop_data   = 64'h1000 + 64'(c);
            #1;
            if (c == 0) r_ready = bus.req_ready;
            else if (bus.req_ready != 0) r_zero_viol++;
            if (bus.q_op_valid) begin
                if (r_pulses == 0) begin
                    r_first_c  = c;
                    r_op_flag  = bus.q_op_flag;
                    r_op_index = bus.q_op_index;
                    r_op_data  = bus.q_op_data;
                end
                r_last_c = c;
                r_pulses++;
            end else if (bus.q_op_flag != 0 || bus.q_op_index != 0 || bus.q_op_data != 0) begin
                r_zero_viol++;
            end
            if (bus.rsp_valid) begin
                if (r_rsp_c < 0) begin
                    r_rsp_c  = c;
                    r_rsp_id = bus.rsp_id;
                    r_status = bus.rsp_status;
                    r_data   = bus.rsp_data;
                end
                r_rsp_cnt++;
            end
        end
        idle_inputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_qop", {63'h0, bus.q_op_valid}, 64'h0);
        check("rst_rsp", {63'h0, bus.rsp_valid}, 64'h0);
        reset = 1'b0;
    endtask

    logic [3:0] g_vec [8];
    int         g_cyc [8];
    int         ngrant;
    int         rsp_seen;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_flag  = '0;
        bus.req_index = '0;
        bus.req_data  = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 64'(bus.req_ready), 64'h0);
        check("reset_qop", {63'h0, bus.q_op_valid}, 64'h0);
        check("reset_qop_fields", {bus.q_op_flag, bus.q_op_index, 56'h0} | bus.q_op_data, 64'h0);
        check("reset_rsp", {61'h0, bus.rsp_valid, bus.rsp_id}, 64'h0);
        check("reset_rsp_fields", {62'h0, bus.rsp_status} | bus.rsp_data, 64'h0);
        reset = 1'b0;

        // Req0 push 0xAB, queue not full.
        run_cmd(0, 2'b00, 6'd0, 64'hAB, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("push_ready", 64'(r_ready), 64'h1);
        check("push_pulses", 64'(r_pulses), 64'd1);
        check("push_issue_cycle", 64'(r_first_c), 64'd1);
        check("push_op_flag", 64'(r_op_flag), 64'h0);
        check("push_op_data", r_op_data, 64'hAB);
        check("push_rsp_cycle", 64'(r_rsp_c), 64'd3);
        check("push_rsp_cnt", 64'(r_rsp_cnt), 64'd1);
        check("push_rsp_id", 64'(r_rsp_id), 64'h0);
        check("push_status", 64'(r_status), 64'h0);
        check("push_rsp_data", r_data, 64'h0);
        check("push_idle_zero", 64'(r_zero_viol), 64'h0);

        // All four held valid: grants 0,1,2,3,0 four cycles apart, starting at index 0 after reset.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_flag[2*i +: 2]   = 2'b00;
            bus.req_data[64*i +: 64] = 64'h10 + 64'(i);
        end
        ngrant = 0;
        @(negedge clk);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready != 0 && ngrant < 8) begin
                g_vec[ngrant] = bus.req_ready;
                g_cyc[ngrant] = c;
                ngrant++;
            end
            if (c == 1) check("rr_first_op_data", bus.q_op_data, 64'h10);
            if (c == 5) check("rr_second_op_data", bus.q_op_data, 64'h11);
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        check("rr_ngrant", 64'(ngrant), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_vec", (k < ngrant) ? 64'(g_vec[k]) : 64'hFF, 64'(4'b0001 << (k % 4)));
            check("rr_grant_cycle", (k < ngrant) ? 64'(g_cyc[k]) : 64'hFF, 64'(4 * k));
        end

        // Pop with q_empty: no queue op, rejected response two cycles after grant.
        run_cmd(2, 2'b01, 6'd0, 64'h0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        check("empty_ready", 64'(r_ready), 64'h4);
        check("empty_pulses", 64'(r_pulses), 64'd0);
        check("empty_rsp_cycle", 64'(r_rsp_c), 64'd2);
        check("empty_rsp_id", 64'(r_rsp_id), 64'd2);
        check("empty_status", 64'(r_status), 64'h1);
        check("empty_rsp_data", r_data, 64'h0);

        // Push with q_full: rejected the same way.
        run_cmd(3, 2'b00, 6'd0, 64'h77, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        check("full_pulses", 64'(r_pulses), 64'd0);
        check("full_rsp_cycle", 64'(r_rsp_c), 64'd2);
        check("full_status", 64'(r_status), 64'h1);

        // Pop with q_error_time on every check: MAX_RETRY+1 issues, timeout at T+9.
        run_cmd(1, 2'b01, 6'd0, 64'h0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
        check("tmo_pulses", 64'(r_pulses), 64'd4);
        check("tmo_last_issue", 64'(r_last_c), 64'd7);
        check("tmo_rsp_cycle", 64'(r_rsp_c), 64'd9);
        check("tmo_rsp_id", 64'(r_rsp_id), 64'd1);
        check("tmo_status", 64'(r_status), 64'h3);
        check("tmo_rsp_data", r_data, 64'h0);
        check("tmo_idle_zero", 64'(r_zero_viol), 64'h0);

        // Pop with error only on the first check: second issue at T+3 supplies the data.
        run_cmd(3, 2'b01, 6'd0, 64'h0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        check("retry_pulses", 64'(r_pulses), 64'd2);
        check("retry_rsp_cycle", 64'(r_rsp_c), 64'd5);
        check("retry_status", 64'(r_status), 64'h0);
        check("retry_rsp_data", r_data, 64'h1003);

        // Plain pop: data captured from the single issue at T+1.
        run_cmd(0, 2'b01, 6'd0, 64'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("pop_rsp_data", r_data, 64'h1001);

        // Modify index 5 with q_error_rem: invalid-index status, no data.
        run_cmd(0, 2'b11, 6'd5, 64'h55, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        check("mod_op_flag", 64'(r_op_flag), 64'h3);
        check("mod_op_index", 64'(r_op_index), 64'd5);
        check("mod_op_data", r_op_data, 64'h55);
        check("mod_rsp_cycle", 64'(r_rsp_c), 64'd3);
        check("mod_status", 64'(r_status), 64'h2);
        check("mod_rsp_data", r_data, 64'h0);

        // Remove with only q_error_reg high: sticky flag must not affect status.
        run_cmd(1, 2'b10, 6'd7, 64'h0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        check("rem_op_index", 64'(r_op_index), 64'd7);
        check("rem_status", 64'(r_status), 64'h0);

        // Push with q_error_rem high: push always reports ok.
        run_cmd(2, 2'b00, 6'd0, 64'h99, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        check("push_rem_status", 64'(r_status), 64'h0);

        // Reset during CHECK of a pop from req2 (rr_ptr is 3 beforehand).
        @(negedge clk);
        bus.req_flag[4 +: 2] = 2'b01;
        bus.req_valid = 4'b0100;
        #1;
        check("mid_grant", 64'(bus.req_ready), 64'h4);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_qop", {63'h0, bus.q_op_valid}, 64'h0);
        check("mid_rst_rsp", {61'h0, bus.rsp_valid, bus.rsp_id}, 64'h0);
        check("mid_rst_fields", {62'h0, bus.rsp_status} | bus.rsp_data | bus.q_op_data, 64'h0);
        reset = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid || bus.q_op_valid) rsp_seen++;
        end
        check("mid_no_rsp", 64'(rsp_seen), 64'h0);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        check("mid_rr_restart", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
